// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - two-requester arbiter in front of one shared 64-bit bitwise ALU
//
// Purpose: accepts one operation at a time from req0/req1 (valid/ready),
// registers its operands onto the shared ALU, captures the ALU result and
// flags one cycle later, and holds the response until resp_ready.
// Sequence per op: IDLE (accept) -> EXEC (ALU settles) -> RESP (hold).
//
// Ports:
//   clk, reset                         clock, async active-high reset
//   reqN_valid/reqN_ready              request handshake, N = 0,1
//   reqN_A, reqN_B, reqN_op            operands and op code per requester
//   alu_A, alu_B, alu_op               registered operands to the shared ALU
//   alu_result, alu_zero, alu_negative shared ALU outputs
//   resp_valid/resp_ready              response handshake
//   resp_id                            owner of the held response
//   result, zero, negative             captured ALU result and flags
//
// Configuration macro: ALU_ARB_FIXED_PRIO_EN
//   defined   - requester 0 always wins a contest
//   undefined - round-robin against last_grant

module alu_rr_arbiter #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_A,
   input  logic [WIDTH-1:0] req0_B,
   input  logic [1:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_A,
   input  logic [WIDTH-1:0] req1_B,
   input  logic [1:0]       req1_op,
   output logic [WIDTH-1:0] alu_A,
   output logic [WIDTH-1:0] alu_B,
   output logic [1:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   input  logic             alu_negative,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [1:0]       alu_op_q, alu_op_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             negative_q, negative_d;
   logic             resp_valid_q, resp_valid_d;
   logic             resp_id_q, resp_id_d;

   logic             grant1;
   logic             idle;

   // grant1 names the requester the arbiter would pick this cycle; it only
   // matters when at least one valid is high.
`ifdef ALU_ARB_FIXED_PRIO_EN
   assign grant1 = req1_valid & ~req0_valid;
`else
   // Requester 1 wins a contest only if requester 0 was granted last.
   assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);
`endif

   assign idle       = (state_q == ST_IDLE);
   assign req0_ready = idle & req0_valid & ~grant1;
   assign req1_ready = idle & grant1;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      result_d     = result_q;
      zero_d       = zero_q;
      negative_d   = negative_q;
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;

      case (state_q)
         ST_IDLE: begin
            if (req0_ready || req1_ready) begin
               alu_a_d      = grant1 ? req1_A  : req0_A;
               alu_b_d      = grant1 ? req1_B  : req0_B;
               alu_op_d     = grant1 ? req1_op : req0_op;
               resp_id_d    = grant1;
               last_grant_d = grant1;
               state_d      = ST_EXEC;
            end
         end
         ST_EXEC: begin
            // The ALU has had a full cycle on the registered operands.
            result_d     = alu_result;
            zero_d       = alu_zero;
            negative_d   = alu_negative;
            resp_valid_d = 1'b1;
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= 2'b00;
         result_q     <= '0;
         zero_q       <= 1'b0;
         negative_q   <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         result_q     <= result_d;
         zero_q       <= zero_d;
         negative_q   <= negative_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
      end
   end

   assign alu_A      = alu_a_q;
   assign alu_B      = alu_b_q;
   assign alu_op     = alu_op_q;
   assign result     = result_q;
   assign zero       = zero_q;
   assign negative   = negative_q;
   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb/tb_alu_rr_arbiter.sv - self-checking bench for alu_rr_arbiter with a behavioural shared ALU
`timescale 1ns/1ps

module tb_alu_rr_arbiter;

   localparam int W = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic         req0_valid, req1_valid;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_A, req0_B, req1_A, req1_B;
   logic [1:0]   req0_op, req1_op;
   logic [W-1:0] alu_A, alu_B;
   logic [1:0]   alu_op;
   logic [W-1:0] alu_result;
   logic         alu_zero, alu_negative;
   logic         resp_valid, resp_ready, resp_id;
   logic [W-1:0] result;
   logic         zero, negative;

   typedef struct packed {
      logic         id;
      logic [W-1:0] res;
      logic         z;
      logic         n;
   } exp_t;

   exp_t         sb[$];
   exp_t         e;
   int           n_tests = 0;
   int           n_fail  = 0;
   logic [W-1:0] last_a, last_b;
   logic [1:0]   last_op;

   always #5000 clk = ~clk;

   alu_rr_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_A(req0_A), .req0_B(req0_B), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_A(req1_A), .req1_B(req1_B), .req1_op(req1_op),
      .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_negative(alu_negative),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .result(result), .zero(zero), .negative(negative)
   );

   function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] op);
      case (op)
         2'b00:   alu_f = a ^ b;
         2'b01:   alu_f = a & b;
         2'b10:   alu_f = a | b;
         default: alu_f = '0;
      endcase
   endfunction

   // Behavioural shared ALU driven by the DUT's registered operands.
   always_comb begin
      alu_result   = alu_f(alu_A, alu_B, alu_op);
      alu_zero     = (alu_result == '0);
      alu_negative = alu_result[W-1];
   end

   function automatic exp_t mk_exp(input logic id, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [1:0] op);
      exp_t x;
      x.id  = id;
      x.res = alu_f(a, b, op);
      x.z   = (x.res == '0);
      x.n   = x.res[W-1];
      return x;
   endfunction

   initial begin
      #50000000;
      $display("FAIL watchdog: simulation did not finish, got running want finished");
      $fatal(1);
   end

   task automatic test_reset();
      reset = 1'b1;
      req0_valid = 0; req1_valid = 0; resp_ready = 0;
      req0_A = '0; req0_B = '0; req0_op = 0;
      req1_A = '0; req1_B = '0; req1_op = 0;
      @(negedge clk);
      n_tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++;
         $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready); end
      n_tests++; if (alu_A !== '0 || alu_B !== '0 || alu_op !== 2'b00) begin n_fail++;
         $display("FAIL reset_alu: got %h %h %b want 0", alu_A, alu_B, alu_op); end
      n_tests++; if (result !== '0 || zero !== 1'b0 || negative !== 1'b0) begin n_fail++;
         $display("FAIL reset_result: got %h z%b n%b want 0", result, zero, negative); end
      n_tests++; if (resp_valid !== 1'b0 || resp_id !== 1'b0) begin n_fail++;
         $display("FAIL reset_resp: got v%b id%b want 0 0", resp_valid, resp_id); end
      req1_valid = 1; #1;
      n_tests++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin n_fail++;
         $display("FAIL reset_req1_only: got %b%b want 01", req0_ready, req1_ready); end
      req1_valid = 0; req0_valid = 1; #1;
      n_tests++; if (req0_ready !== 1'b1) begin n_fail++;
         $display("FAIL reset_req0_only: got %b want 1", req0_ready); end
      req0_valid = 0;
      @(negedge clk); reset = 1'b0;
      last_a = '0; last_b = '0; last_op = 0;
   endtask

   task automatic test_single_op();
      req0_A = 64'd1; req0_B = 64'hFFFF_FFFF_FFFF_FFFF; req0_op = 2'b00;
      req0_valid = 1; resp_ready = 1; #1;
      n_tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++;
         $display("FAIL single_accept: got %b%b want 10", req0_ready, req1_ready); end
      sb.push_back(mk_exp(1'b0, req0_A, req0_B, req0_op));
      last_a = req0_A; last_b = req0_B; last_op = req0_op;
      @(negedge clk); req0_valid = 0;
      n_tests++; if (resp_valid !== 1'b0 || alu_A !== last_a || alu_B !== last_b) begin n_fail++;
         $display("FAIL single_exec: got v%b A=%h B=%h want v0 A=%h B=%h", resp_valid, alu_A, alu_B, last_a, last_b); end
      @(negedge clk);
      n_tests++; if (resp_valid !== 1'b1) begin n_fail++;
         $display("FAIL single_valid: got %b want 1", resp_valid); end
      if (sb.size() == 0) begin n_tests++; n_fail++; $display("FAIL single_sb: got empty want entry"); end
      else begin
         e = sb.pop_front();
         n_tests++; if (resp_id !== e.id || result !== e.res || zero !== e.z || negative !== e.n) begin n_fail++;
            $display("FAIL single_resp: got id%b %h z%b n%b want id%b %h z%b n%b",
                     resp_id, result, zero, negative, e.id, e.res, e.z, e.n); end
      end
      @(negedge clk);
      n_tests++; if (resp_valid !== 1'b0) begin n_fail++;
         $display("FAIL single_consumed: got %b want 0", resp_valid); end
   endtask

   task automatic test_contention();
      logic lg, g;
      reset = 1'b1; @(negedge clk); reset = 1'b0;
      lg = 1'b1;
      req0_A = '0; req0_B = '0; req0_op = 2'b00;
      req1_A = '0; req1_B = 64'd2; req1_op = 2'b10;
      req0_valid = 1; req1_valid = 1; resp_ready = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
         g = 1'b0;
`else
         g = ~lg;
`endif
         n_tests++; if (req0_ready !== ~g || req1_ready !== g) begin n_fail++;
            $display("FAIL contention_grant%0d: got %b%b want %b%b", i, req0_ready, req1_ready, ~g, g); end
         if (g) begin sb.push_back(mk_exp(1'b1, req1_A, req1_B, req1_op)); last_a = req1_A; last_b = req1_B; last_op = req1_op; end
         else   begin sb.push_back(mk_exp(1'b0, req0_A, req0_B, req0_op)); last_a = req0_A; last_b = req0_B; last_op = req0_op; end
         lg = g;
         @(negedge clk);
         n_tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++;
            $display("FAIL contention_exec_ready%0d: got %b%b want 00", i, req0_ready, req1_ready); end
         @(negedge clk);
         if (sb.size() == 0) begin n_tests++; n_fail++; $display("FAIL contention_sb%0d: got empty want entry", i); end
         else begin
            e = sb.pop_front();
            n_tests++; if (resp_valid !== 1'b1 || resp_id !== e.id || result !== e.res || zero !== e.z || negative !== e.n) begin n_fail++;
               $display("FAIL contention_resp%0d: got v%b id%b %h z%b n%b want v1 id%b %h z%b n%b",
                        i, resp_valid, resp_id, result, zero, negative, e.id, e.res, e.z, e.n); end
         end
         @(negedge clk);
      end
      req0_valid = 0; req1_valid = 0;
   endtask

   task automatic test_backpressure();
      req1_A = 64'hF0F0_F0F0_F0F0_F0F0; req1_B = 64'hFF00_FF00_FF00_FF00; req1_op = 2'b01;
      req1_valid = 1; resp_ready = 0; #1;
      n_tests++; if (req1_ready !== 1'b1) begin n_fail++;
         $display("FAIL bp_accept: got %b want 1", req1_ready); end
      sb.push_back(mk_exp(1'b1, req1_A, req1_B, req1_op));
      last_a = req1_A; last_b = req1_B; last_op = req1_op;
      @(negedge clk); req1_valid = 0;
      @(negedge clk);
      req0_A = 64'd5; req0_B = 64'd3; req0_op = 2'b10; req0_valid = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         e = (sb.size() != 0) ? sb[0] : '0;
         n_tests++; if (resp_valid !== 1'b1 || resp_id !== e.id || result !== e.res || zero !== e.z || negative !== e.n) begin n_fail++;
            $display("FAIL bp_hold%0d: got v%b id%b %h z%b n%b want v1 id%b %h z%b n%b",
                     i, resp_valid, resp_id, result, zero, negative, e.id, e.res, e.z, e.n); end
         n_tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || alu_A !== last_a) begin n_fail++;
            $display("FAIL bp_no_accept%0d: got rdy %b%b A=%h want 00 A=%h", i, req0_ready, req1_ready, alu_A, last_a); end
         @(negedge clk);
      end
      resp_ready = 1;
      if (sb.size() != 0) e = sb.pop_front();
      @(negedge clk); #1;
      n_tests++; if (resp_valid !== 1'b0 || req0_ready !== 1'b1) begin n_fail++;
         $display("FAIL bp_release: got v%b rdy0 %b want v0 rdy0 1", resp_valid, req0_ready); end
      sb.push_back(mk_exp(1'b0, req0_A, req0_B, req0_op));
      last_a = req0_A; last_b = req0_B; last_op = req0_op;
      @(negedge clk); req0_valid = 0;
      @(negedge clk);
      if (sb.size() == 0) begin n_tests++; n_fail++; $display("FAIL bp_sb: got empty want entry"); end
      else begin
         e = sb.pop_front();
         n_tests++; if (resp_valid !== 1'b1 || resp_id !== e.id || result !== e.res || zero !== e.z || negative !== e.n) begin n_fail++;
            $display("FAIL bp_next_resp: got v%b id%b %h z%b n%b want v1 id%b %h z%b n%b",
                     resp_valid, resp_id, result, zero, negative, e.id, e.res, e.z, e.n); end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op();
      req0_A = 64'h8000_0000_0000_0001; req0_B = 64'd0; req0_op = 2'b10;
      req0_valid = 1; resp_ready = 1;
      @(negedge clk); req0_valid = 0;
      #1 reset = 1'b1; #1;
      sb.delete();
      n_tests++; if (resp_valid !== 1'b0 || result !== '0 || alu_A !== '0 || resp_id !== 1'b0) begin n_fail++;
         $display("FAIL midreset_clear: got v%b %h A=%h id%b want 0", resp_valid, result, alu_A, resp_id); end
      req1_A = 64'h0123_4567_89AB_CDEF; req1_B = 64'hFFFF_0000_FFFF_0000; req1_op = 2'b00;
      req1_valid = 1;
      @(negedge clk); reset = 1'b0; #1;
      n_tests++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin n_fail++;
         $display("FAIL midreset_grant: got %b%b want 01", req0_ready, req1_ready); end
      sb.push_back(mk_exp(1'b1, req1_A, req1_B, req1_op));
      last_a = req1_A; last_b = req1_B; last_op = req1_op;
      @(negedge clk); req1_valid = 0;
      n_tests++; if (resp_valid !== 1'b0) begin n_fail++;
         $display("FAIL midreset_no_resp: got %b want 0", resp_valid); end
      @(negedge clk);
      if (sb.size() == 0) begin n_tests++; n_fail++; $display("FAIL midreset_sb: got empty want entry"); end
      else begin
         e = sb.pop_front();
         n_tests++; if (resp_valid !== 1'b1 || resp_id !== e.id || result !== e.res || zero !== e.z || negative !== e.n) begin n_fail++;
            $display("FAIL midreset_resp: got v%b id%b %h z%b n%b want v1 id%b %h z%b n%b",
                     resp_valid, resp_id, result, zero, negative, e.id, e.res, e.z, e.n); end
      end
      @(negedge clk);
   endtask

   task automatic test_idle_hold();
      req0_valid = 0; req1_valid = 0; resp_ready = 1;
      for (int i = 0; i < 10; i++) begin
         #1;
         n_tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || resp_valid !== 1'b0 ||
                        alu_A !== last_a || alu_B !== last_b || alu_op !== last_op) begin n_fail++;
            $display("FAIL idle_hold%0d: got rdy %b%b v%b A=%h B=%h op=%b want 00 0 A=%h B=%h op=%b",
                     i, req0_ready, req1_ready, resp_valid, alu_A, alu_B, alu_op, last_a, last_b, last_op); end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_contention();
      test_backpressure();
      test_reset_mid_op();
      test_idle_hold();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_rr_arbiter.md
# alu_rr_arbiter

Sequential controller that shares one 64-bit bitwise ALU unit (XOR/AND/OR datapath with zero/negative flags) between two requesters. It sits between two issuing agents and the single shared ALU instance. Each request is accepted with a valid/ready handshake, registered, and driven onto the shared ALU. The ALU outputs are captured into a result register, and the response is held until consumed.

## Interface
- WIDTH, 64, operand/result width in bits
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- req0_valid, req1_valid  input  1  requester N has an operation pending
- req0_ready, req1_ready  output  1  requester N's operation is accepted at this edge (when valid is also high)
- req0_A, req0_B, req1_A, req1_B  input  WIDTH  operands per requester
- req0_op, req1_op  input  2  op code: 00 XOR, 01 AND, 10 OR, 11 reserved (forwarded unchanged)
- alu_A, alu_B  output  WIDTH  registered operands to the shared ALU
- alu_op  output  2  registered op code to the shared ALU
- alu_result  input  WIDTH  shared ALU result
- alu_zero, alu_negative  input  1  shared ALU flags
- resp_valid  output  1  response held in the result register
- resp_ready  input  1  consumer takes the response this edge
- resp_id  output  1  requester that owns the response (0 or 1)
- result  output  WIDTH  captured ALU result
- zero, negative  output  1  captured ALU flags

## Operation
- States: IDLE, EXEC, RESP.
- IDLE:
  - Arbiter selects a requester.
  - reqN_ready is high only for the selected requester, and only while its valid is high.
  - reqN_ready may depend combinationally on reqN_valid. Requesters must not make valid depend on ready.
  - On handshake, latch A/B/op into alu_A/alu_B/alu_op, record owner in resp_id, update last_grant, then go to EXEC.
- EXEC: one full cycle for the shared ALU to settle. At the next edge, capture alu_result/alu_zero/alu_negative into result/zero/negative, set resp_valid, then go to RESP.
- RESP:
  - Hold result, flags and resp_id stable; both readies stay low.
  - On resp_valid && resp_ready, clear resp_valid and go to IDLE.
  - result, flags and resp_id keep their last values after the response is consumed.
- Arbitration (round-robin):
  - Only one valid requester: grant it.
  - Both valid: grant the requester that is not last_grant.
  - last_grant is 1 after reset, so requester 0 wins the first contest.
- No requests in IDLE: remain in IDLE. alu_* outputs hold their last values.
- Op 11 is not checked; it is forwarded to the ALU.
- Arithmetic: none in this block; all WIDTH-bit values pass through unmodified.

## Timing
- Reset values:
  - state IDLE, last_grant 1
  - req0_ready 0 unless req0_valid, req1_ready 0 unless the IDLE arbitration rule selects it
  - alu_A, alu_B, alu_op, result 0
  - zero 0, negative 0, resp_valid 0, resp_id 0
- Handshake at edge k: EXEC during cycle k to k+1; capture at edge k+1, so resp_valid is high after k+1 (2-edge latency from accept to response).
- If resp_ready is already high when resp_valid rises: consumed at edge k+2, IDLE after k+2, next accept no earlier than edge k+3. Peak throughput is one op per 3 cycles.
- resp_ready held low: RESP persists indefinitely and no new request is accepted (backpressure).
- Reset mid-operation (EXEC or RESP): in-flight op and pending response are discarded, all registers return to reset values asynchronously, and no response is issued.
- The shared ALU path (gate delays) must settle within one clock period. The bench clock period is 10000 ns.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: fixed priority. Requester 0 always wins when both are valid; last_grant is still tracked but ignored.
- ALU_ARB_FIXED_PRIO_EN undefined: round-robin as described in Operation.

## Test plan
- Single op: after reset, req0 A=1, B=64'hFFFFFFFFFFFFFFFF, op=00, resp_ready=1 -> req0_ready=1 at accept; two edges later resp_valid=1, resp_id=0, result=64'hFFFFFFFFFFFFFFFE, zero=0, negative=1.
- Contention round-robin: both valid every cycle (req0 op=00 A=B=0; req1 op=10 A=0, B=2) -> grants alternate 0,1,0,1. The req0 response has result=0 and zero=1; the req1 response has result=2. With ALU_ARB_FIXED_PRIO_EN, every grant goes to requester 0.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> result, flags and resp_id stable; both readies 0; no new accept until resp_ready=1.
- Reset mid-op: assert reset during EXEC -> resp_valid=0, result=0, state IDLE immediately. After release with req1 only valid, req1 is granted.
- Idle hold: no valids for 10 cycles -> readies 0, resp_valid 0, alu_* unchanged.
